// File: rtl/i2c_slave_expander_n.sv
// Oversampled I2C slave port expander with NUM_PORTS auto-incrementing 8-bit ports.
// Define I2C_EXP_INT_EN to enable the change-detect interrupt on int_n.

module i2c_exp_filt #(
  parameter int FILT_LEN = 3
) (
  input  logic clk,
  input  logic start_and_reset_delayed,
  input  logic pin,
  output logic filt
);
  localparam logic [3:0] FL_M1 = 4'(FILT_LEN - 1);

  logic       s1, s2;
  logic [3:0] cnt;

  // Idle bus is high, so everything resets to 1 to avoid a spurious edge.
  always_ff @(posedge clk or negedge start_and_reset_delayed) begin
    if (!start_and_reset_delayed) begin
      s1   <= 1'b1;
      s2   <= 1'b1;
      filt <= 1'b1;
      cnt  <= 4'd0;
    end else begin
      s1 <= pin;
      s2 <= s1;
      if (s2 == filt) begin
        cnt <= 4'd0;
      end else if (cnt == FL_M1) begin
        filt <= s2;
        cnt  <= 4'd0;
      end else begin
        cnt <= cnt + 4'd1;
      end
    end
  end
endmodule

module i2c_slave_expander_n #(
  parameter int NUM_PORTS = 1,
  parameter int FILT_LEN  = 3
) (
  input  logic                   clk,
  input  logic                   start_and_reset_delayed,
  input  logic                   scl_i,
  input  logic                   sda_i,
  output logic                   sda_oe,
  input  logic [6:0]             adr,
  input  logic [8*NUM_PORTS-1:0] io_in,
  output logic [8*NUM_PORTS-1:0] io_out,
  output logic                   int_n
);
  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] ADDR     = 3'd1;
  localparam logic [2:0] ADDR_ACK = 3'd2;
  localparam logic [2:0] WR       = 3'd3;
  localparam logic [2:0] WR_ACK   = 3'd4;
  localparam logic [2:0] RD       = 3'd5;
  localparam logic [2:0] RD_ACK   = 3'd6;
  localparam logic [2:0] WAIT     = 3'd7;

  localparam logic [1:0] LAST_IDX = 2'(NUM_PORTS - 1);

  logic                   scl_f, sda_f, scl_d, sda_d;
  logic                   scl_rise, scl_fall, start_ev, stop_ev;
  logic [8*NUM_PORTS-1:0] io_s1, io_sync;
  logic [2:0]             state;
  logic [3:0]             bit_cnt;
  logic [7:0]             shreg, rd_sh, io_sel;
  logic [1:0]             idx, idx_nxt;
  logic                   rw;

  i2c_exp_filt #(.FILT_LEN(FILT_LEN)) u_scl_filt (
    .clk                     (clk),
    .start_and_reset_delayed (start_and_reset_delayed),
    .pin                     (scl_i),
    .filt                    (scl_f)
  );

  i2c_exp_filt #(.FILT_LEN(FILT_LEN)) u_sda_filt (
    .clk                     (clk),
    .start_and_reset_delayed (start_and_reset_delayed),
    .pin                     (sda_i),
    .filt                    (sda_f)
  );

  always_ff @(posedge clk or negedge start_and_reset_delayed) begin
    if (!start_and_reset_delayed) begin
      scl_d   <= 1'b1;
      sda_d   <= 1'b1;
      io_s1   <= '1;
      io_sync <= '1;
    end else begin
      scl_d   <= scl_f;
      sda_d   <= sda_f;
      io_s1   <= io_in;
      io_sync <= io_s1;
    end
  end

  assign scl_rise = scl_f & ~scl_d;
  assign scl_fall = ~scl_f & scl_d;
  assign start_ev = scl_f & scl_d & sda_d & ~sda_f;
  assign stop_ev  = scl_f & scl_d & ~sda_d & sda_f;
  assign idx_nxt  = (idx == LAST_IDX) ? 2'd0 : idx + 2'd1;

  always_comb begin
    io_sel = io_sync[7:0];
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (idx == 2'(k)) io_sel = io_sync[8*k +: 8];
    end
  end

  // Stop outranks start, and both outrank bit sampling in the same clk.
  always_ff @(posedge clk or negedge start_and_reset_delayed) begin
    if (!start_and_reset_delayed) begin
      state   <= IDLE;
      bit_cnt <= 4'd0;
      shreg   <= 8'hFF;
      rd_sh   <= 8'hFF;
      idx     <= 2'd0;
      rw      <= 1'b0;
      sda_oe  <= 1'b0;
      io_out  <= '1;
    end else if (stop_ev) begin
      state  <= IDLE;
      sda_oe <= 1'b0;
    end else if (start_ev) begin
      state   <= ADDR;
      bit_cnt <= 4'd0;
      idx     <= 2'd0;
      sda_oe  <= 1'b0;
    end else if (scl_rise) begin
      case (state)
        ADDR, WR: begin
          if (bit_cnt != 4'd8) begin
            shreg   <= {shreg[6:0], sda_f};
            bit_cnt <= bit_cnt + 4'd1;
          end
        end
        RD: begin
          if (bit_cnt != 4'd8) bit_cnt <= bit_cnt + 4'd1;
        end
        WR_ACK: begin
          for (int k = 0; k < NUM_PORTS; k++) begin
            if (idx == 2'(k)) io_out[8*k +: 8] <= shreg;
          end
          idx     <= idx_nxt;
          state   <= WR;
          bit_cnt <= 4'd0;
        end
        RD_ACK: begin
          if (!sda_f) begin
            idx     <= idx_nxt;
            state   <= RD;
            bit_cnt <= 4'd0;
          end else begin
            state <= WAIT;
          end
        end
        default: ;
      endcase
    end else if (scl_fall) begin
      case (state)
        ADDR: begin
          if (bit_cnt == 4'd8) begin
            if (shreg[7:1] == adr) begin
              state  <= ADDR_ACK;
              sda_oe <= 1'b1;
              rw     <= shreg[0];
            end else begin
              state <= WAIT;
            end
          end
        end
        ADDR_ACK: begin
          bit_cnt <= 4'd0;
          if (rw) begin
            state  <= RD;
            rd_sh  <= io_sel;
            sda_oe <= ~io_sel[7];
          end else begin
            state  <= WR;
            sda_oe <= 1'b0;
          end
        end
        WR: begin
          if (bit_cnt == 4'd8) begin
            state  <= WR_ACK;
            sda_oe <= 1'b1;
          end else begin
            sda_oe <= 1'b0;
          end
        end
        RD: begin
          if (bit_cnt == 4'd8) begin
            state  <= RD_ACK;
            sda_oe <= 1'b0;
          end else if (bit_cnt == 4'd0) begin
            rd_sh  <= io_sel;
            sda_oe <= ~io_sel[7];
          end else begin
            sda_oe <= ~rd_sh[3'd7 - bit_cnt[2:0]];
          end
        end
        default: sda_oe <= 1'b0;
      endcase
    end
  end

`ifdef I2C_EXP_INT_EN
  logic [8*NUM_PORTS-1:0] snap;
  logic [2:0]             state_d;
  logic                   snap_load;

  // Reload one clk after entering a read ADDR_ACK or any WR_ACK.
  assign snap_load = ((state == ADDR_ACK) && (state_d != ADDR_ACK) && rw) ||
                     ((state == WR_ACK) && (state_d != WR_ACK));

  always_ff @(posedge clk or negedge start_and_reset_delayed) begin
    if (!start_and_reset_delayed) begin
      snap    <= '1;
      state_d <= IDLE;
      int_n   <= 1'b1;
    end else begin
      state_d <= state;
      if (snap_load) begin
        snap  <= io_sync;
        int_n <= 1'b1;
      end else begin
        int_n <= (io_sync == snap);
      end
    end
  end
`else
  assign int_n = 1'b1;
`endif

endmodule

// File: tb/tb_i2c_slave_expander_n.sv
// Scoreboard bench: bit-banged I2C master against a 2-port expander at address 0x20.
module tb_i2c_slave_expander_n;
  localparam int NP = 2;
  localparam int FL = 3;
  localparam int Q  = 10;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        scl_i, sda_m, sda_i, sda_oe, int_n;
  logic [6:0]  adr = 7'h20;
  logic [15:0] io_in, io_out;
  int          n_vec = 0, n_err = 0, oe_hits = 0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;
  assign sda_i = sda_m & ~sda_oe;
  always @(posedge clk) if (sda_oe === 1'b1) oe_hits <= oe_hits + 1;

  i2c_slave_expander_n #(.NUM_PORTS(NP), .FILT_LEN(FL)) dut (
    .clk                     (clk),
    .start_and_reset_delayed (rst_n),
    .scl_i                   (scl_i),
    .sda_i                   (sda_i),
    .sda_oe                  (sda_oe),
    .adr                     (adr),
    .io_in                   (io_in),
    .io_out                  (io_out),
    .int_n                   (int_n)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  task automatic sb_chk(input string tag, input logic [15:0] obs);
    logic [15:0] e;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
    chk(tag, obs, e);
  endtask

  task automatic wclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; scl_i = 1'b1; wclk(Q);
    sda_m = 1'b0; wclk(Q);
    scl_i = 1'b0; wclk(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wclk(Q);
    scl_i = 1'b1; wclk(Q);
    sda_m = 1'b1; wclk(Q);
  endtask

  // Glitch mode adds a 1-clk pulse in both SCL phases.
  task automatic wbit(input logic b, input logic glitch);
    sda_m = b;
    if (glitch) begin
      wclk(3); scl_i = 1'b1; wclk(1); scl_i = 1'b0; wclk(Q - 4);
      scl_i = 1'b1; wclk(5); scl_i = 1'b0; wclk(1); scl_i = 1'b1; wclk(2*Q - 6);
    end else begin
      wclk(Q); scl_i = 1'b1; wclk(2*Q);
    end
    scl_i = 1'b0; wclk(Q);
  endtask

  task automatic rbit(output logic b);
    sda_m = 1'b1; wclk(Q);
    scl_i = 1'b1; wclk(Q);
    b = sda_i; wclk(Q);
    scl_i = 1'b0; wclk(Q);
  endtask

  task automatic wr_byte(input logic [7:0] d, input logic exp_ack, input logic glitch,
                         input string tag);
    logic b;
    exp_q.push_back({15'd0, exp_ack});
    for (int i = 7; i >= 0; i--) wbit(d[i], glitch);
    rbit(b);
    sb_chk(tag, {15'd0, ~b});
  endtask

  task automatic rd_byte(input logic [7:0] exp_d, input logic mack, input string tag);
    logic [7:0] d;
    logic       b;
    exp_q.push_back({8'd0, exp_d});
    for (int i = 7; i >= 0; i--) begin
      rbit(b);
      d[i] = b;
    end
    wbit(~mack, 1'b0);
    sb_chk(tag, {8'd0, d});
  endtask

  initial begin
    #600us;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic b;
    int   h;
    rst_n = 1'b0; scl_i = 1'b1; sda_m = 1'b1; io_in = 16'hFFFF;
    wclk(3);
    chk("rst_io_out", io_out, 16'hFFFF);
    chk("rst_sda_oe", {15'd0, sda_oe}, 16'd0);
    chk("rst_int_n", {15'd0, int_n}, 16'd1);
    rst_n = 1'b1;
    wclk(10);

    i2c_start();
    wr_byte(8'h40, 1'b1, 1'b0, "t1_adr_ack");
    wr_byte(8'h5A, 1'b1, 1'b0, "t1_d0_ack");
    wr_byte(8'hC3, 1'b1, 1'b0, "t1_d1_ack");
    exp_q.push_back(16'hC35A);
    sb_chk("t1_io_out", io_out);
    i2c_stop();

    i2c_start();
    wr_byte(8'h40, 1'b1, 1'b0, "t2_adr_ack");
    wr_byte(8'h11, 1'b1, 1'b0, "t2_d0_ack");
    wr_byte(8'h22, 1'b1, 1'b0, "t2_d1_ack");
    wr_byte(8'h33, 1'b1, 1'b0, "t2_d2_ack");
    i2c_stop();
    exp_q.push_back(16'h2233);
    sb_chk("t2_wrap_io_out", io_out);

    io_in = 16'hBEEF;
    wclk(5);
    i2c_start();
    wr_byte(8'h41, 1'b1, 1'b0, "t3_adr_ack");
    rd_byte(8'hEF, 1'b1, "t3_rd0");
    rd_byte(8'hBE, 1'b0, "t3_rd1");
    exp_q.push_back(16'd0);
    sb_chk("t3_sda_released", {15'd0, sda_oe});
    i2c_stop();

`ifdef I2C_EXP_INT_EN
    io_in = io_in ^ 16'h0008;
    wclk(4);
    exp_q.push_back(16'd0);
    sb_chk("int_assert", {15'd0, int_n});
    i2c_start();
    wr_byte(8'h41, 1'b1, 1'b0, "int_adr_ack");
    exp_q.push_back(16'd1);
    sb_chk("int_release", {15'd0, int_n});
    rd_byte(8'hE7, 1'b0, "int_rd0");
    i2c_stop();
`else
    io_in = io_in ^ 16'h0008;
    wclk(4);
    exp_q.push_back(16'd1);
    sb_chk("int_tied_high", {15'd0, int_n});
`endif

    h = oe_hits;
    i2c_start();
    wr_byte(8'h42, 1'b0, 1'b0, "t4_adr_nack");
    wr_byte(8'h99, 1'b0, 1'b0, "t4_d_nack");
    i2c_stop();
    exp_q.push_back(16'd0);
    sb_chk("t4_oe_cycles", 16'(oe_hits - h));
    exp_q.push_back(16'h2233);
    sb_chk("t4_io_out", io_out);

    i2c_start();
    wr_byte(8'h40, 1'b1, 1'b0, "t5_adr_ack");
    wr_byte(8'h5A, 1'b1, 1'b1, "t5_glitch_d0");
    wr_byte(8'h0F, 1'b1, 1'b1, "t5_glitch_d1");
    i2c_stop();
    exp_q.push_back(16'h0F5A);
    sb_chk("t5_io_out", io_out);

    i2c_start();
    wr_byte(8'h40, 1'b1, 1'b0, "t6_adr_ack");
    for (int i = 0; i < 4; i++) wbit(1'b0, 1'b0);
    i2c_stop();
    exp_q.push_back(16'h0F5A);
    sb_chk("t6_stop_io_out", io_out);

    i2c_start();
    wr_byte(8'h41, 1'b1, 1'b0, "t7_adr_ack");
    for (int i = 0; i < 3; i++) rbit(b);
    exp_q.push_back(16'd1);
    sb_chk("t7_drive_low", {15'd0, sda_oe});
    rst_n = 1'b0;
    #1;
    exp_q.push_back(16'd0);
    sb_chk("t7_rst_sda_oe", {15'd0, sda_oe});
    exp_q.push_back(16'hFFFF);
    sb_chk("t7_rst_io_out", io_out);
    wclk(2);
    rst_n = 1'b1;
    wclk(5);
    i2c_stop();

    i2c_start();
    wr_byte(8'h40, 1'b1, 1'b0, "t8_adr_ack");
    wr_byte(8'hAB, 1'b1, 1'b0, "t8_d0_ack");
    i2c_stop();
    exp_q.push_back(16'hFFAB);
    sb_chk("t8_io_out", io_out);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/i2c_slave_expander_n.md
# i2c_slave_expander_n

Clocked I2C slave port expander, NUM_PORTS bytes wide, with write, read-back of input pins and open-drain interrupt. It is the multi-port successor to the asynchronous 8-bit expander in the power-control CPLD. SCL/SDA are oversampled on clk, so there are no SDA-clocked flops. It adds auto-incrementing multi-byte access and a change-detect interrupt.

## Interface
- NUM_PORTS, 1, number of 8-bit ports (1..4)
- FILT_LEN, 3, glitch-filter length in clk cycles (1..15)
- clk  in  1  sampling clock, ≥ 20 × SCL rate
- start_and_reset_delayed  in  1  reset, asynchronous, active-low
- scl_i  in  1  SCL pin level
- sda_i  in  1  SDA pin level
- sda_oe  out  1  1 = pull SDA low; pad is open-drain, released otherwise
- adr  in  7  device address, static
- io_in  in  8*NUM_PORTS  input pins, asynchronous
- io_out  out  8*NUM_PORTS  output latch; port k = io_out[8k+7:8k]
- int_n  out  1  interrupt, active-low

## Operation
- Reset values: io_out all 1s, sda_oe 0, int_n 1, state IDLE, byte index 0, shift register all 1s.
- Input conditioning:
  - scl_i and sda_i pass a 2-FF synchronizer, then a filter.
  - The filtered level changes only after FILT_LEN consecutive equal samples.
  - io_in passes a 2-FF synchronizer.
- Bus events:
  - Start = filtered SDA fall while SCL high.
  - Stop = filtered SDA rise while SCL high.
  - Bit sampling happens on the filtered SCL rise; sda_oe changes only on the filtered SCL fall.
- FSM states: IDLE, ADDR, ADDR_ACK, WR, WR_ACK, RD, RD_ACK, WAIT.
- Start (from any state, including mid-byte) → ADDR, bit count 0, byte index 0.
- Stop (from any state) → IDLE; sda_oe is 0 on the next clk.
- ADDR: shift 8 bits MSB first (7 address bits, then R/W).
  - Address == adr → ADDR_ACK, sda_oe 1 for the 9th clock.
  - Otherwise → WAIT, never driving SDA until the next start.
- Write path:
  - ADDR_ACK with R/W=0 → WR.
  - After 8 bits → WR_ACK with sda_oe 1.
  - On the 9th SCL rise, the shift register is copied to port[index], the index increments, and the state returns to WR.
  - Index wraps NUM_PORTS-1 → 0.
- Read path:
  - ADDR_ACK with R/W=1 → RD. On the SCL fall ending the ACK, synchronized io_in port[index] is captured.
  - sda_oe = ~bit, MSB first. After 8 bits → RD_ACK and sda_oe 0.
  - Master ACK (SDA=0 on the 9th rise): index increments with wrap, then RD with a new capture.
  - Master NACK → WAIT.
- Start while the slave drives SDA low is not detectable; the master is required not to issue one. Stop/start detection remains active in all states.
- Pin-driven reset mid-transfer: state returns to IDLE immediately and io_out returns to all 1s.

## Timing
- Pin-to-filtered-event latency: 2 + FILT_LEN clk.
- sda_oe update: registered, 1 clk after the filtered SCL fall.
- io_out update: 1 clk after the filtered 9th SCL rise of a write byte. All 8 bits of a port change in the same clk.
- Read capture: 1 clk after the filtered SCL fall; data is stable for the whole byte.
- Minimum clk: 20 × fSCL (8 MHz for 400 kHz).
- Simultaneous stop and bit sample in one clk: stop wins and the bit is discarded.

## Configuration
- I2C_EXP_INT_EN defined:
  - A snapshot register of synchronized io_in is kept.
  - int_n = 0 whenever synchronized io_in ≠ snapshot, registered.
  - Snapshot reload and int_n release happen at a read ADDR_ACK or at any WR_ACK.
- Undefined: no snapshot logic; int_n tied 1.

## Test plan
- NUM_PORTS=2, adr=7'h20; write 0x40, 0x5A, 0xC3 → ACK on all three bytes; io_out=16'hC35A after the last ACK.
- Wrap: NUM_PORTS=2, write 0x40, 0x11, 0x22, 0x33 → io_out=16'h2233 (port0 overwritten with 0x33).
- Read: io_in=16'hBEEF, 0x41, master ACK, then NACK → bytes 0xEF then 0xBE; SDA released after the NACK.
- Address mismatch 0x42 → no ACK, sda_oe 0 throughout, io_out unchanged.
- Robustness:
  - 1-clk glitches on SCL → ignored.
  - Stop injected after bit 4 of a write → IDLE, io_out unchanged.
  - Reset pulse mid-read → sda_oe 0 immediately, io_out all 1s.
- With I2C_EXP_INT_EN: toggle io_in bit 3 → int_n=0 within 4 clk; 0x41 read → int_n=1 after ADDR_ACK.
